// File: rtl/heartbeat_multi.sv
// Multi-channel heartbeat generator: each channel produces an OFF/TOGGLE/PULSE/PWM
// waveform from its own period counter, reconfigured glitch-free through shadow registers.
module heartbeat_multi #(
  parameter int               CHANNELS     = 4,
  parameter int               CNT_W        = 16,
  parameter int               CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter logic [1:0]       RESET_MODE   = 2'd1,
  parameter logic [CNT_W-1:0] RESET_PERIOD = '1,
  parameter logic [CNT_W-1:0] RESET_DUTY   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [1:0]          cfg_field,
  input  logic [CNT_W-1:0]    cfg_data,
  input  logic                restart,
  output logic [CHANNELS-1:0] sig,
  output logic [CHANNELS-1:0] sig_oe,
  output logic [CHANNELS-1:0] wrap
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_PULSE  = 2'd2,
    MODE_PWM    = 2'd3
  } mode_e;

  localparam logic [1:0] FIELD_PERIOD = 2'd0;
  localparam logic [1:0] FIELD_DUTY   = 2'd1;
  localparam logic [1:0] FIELD_MODE   = 2'd2;

  mode_e            mode_q    [CHANNELS];
  mode_e            mode_d    [CHANNELS];
  logic [CNT_W-1:0] cnt_q     [CHANNELS];
  logic [CNT_W-1:0] cnt_d     [CHANNELS];
  logic [CNT_W-1:0] per_q     [CHANNELS];
  logic [CNT_W-1:0] per_d     [CHANNELS];
  logic [CNT_W-1:0] duty_q    [CHANNELS];
  logic [CNT_W-1:0] duty_d    [CHANNELS];
  logic [CNT_W-1:0] per_sh_q  [CHANNELS];
  logic [CNT_W-1:0] per_sh_d  [CHANNELS];
  logic [CNT_W-1:0] duty_sh_q [CHANNELS];
  logic [CNT_W-1:0] duty_sh_d [CHANNELS];

  logic [CHANNELS-1:0] sig_q, sig_d;
  logic [CHANNELS-1:0] oe_q, oe_d;
  logic [CHANNELS-1:0] wrap_q, wrap_d;
  logic [CHANNELS-1:0] sel_s;
  logic [CHANNELS-1:0] mode_wr_s;
  logic [CHANNELS-1:0] wrap_ev_s;

  // Write-port decode and per-channel wrap detection; out-of-range channels match nothing.
  always_comb begin
    sel_s     = '0;
    mode_wr_s = '0;
    wrap_ev_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_s[i]     = cfg_we && (int'(cfg_chan) == i);
      mode_wr_s[i] = sel_s[i] && (cfg_field == FIELD_MODE);
      wrap_ev_s[i] = (mode_q[i] != MODE_OFF) && (cnt_q[i] == per_q[i]);
    end
  end

  // Next-state for every channel: restart/mode re-arm, then counter and waveform.
  always_comb begin
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    duty_d    = duty_q;
    per_sh_d  = per_sh_q;
    duty_sh_d = duty_sh_q;
    sig_d     = sig_q;
    oe_d      = oe_q;
    wrap_d    = wrap_q;
    for (int i = 0; i < CHANNELS; i++) begin
      // Shadow writes never touch the active copy, so any same-cycle copy sees the old value.
      if (sel_s[i]) begin
        case (cfg_field)
          FIELD_PERIOD: per_sh_d[i]  = cfg_data;
          FIELD_DUTY:   duty_sh_d[i] = cfg_data;
          default:      per_sh_d[i]  = per_sh_q[i];
        endcase
      end else begin
        per_sh_d[i] = per_sh_q[i];
      end

      if (restart || mode_wr_s[i]) begin
        if (mode_wr_s[i]) begin
          mode_d[i] = mode_e'(cfg_data[1:0]);
        end else begin
          mode_d[i] = mode_q[i];
        end
        cnt_d[i]  = '0;
        sig_d[i]  = 1'b0;
        wrap_d[i] = 1'b0;
        per_d[i]  = per_sh_q[i];
        duty_d[i] = duty_sh_q[i];
      end else if (mode_q[i] == MODE_OFF) begin
        cnt_d[i]  = '0;
        sig_d[i]  = 1'b0;
        wrap_d[i] = 1'b0;
      end else begin
        wrap_d[i] = wrap_ev_s[i];
        if (wrap_ev_s[i]) begin
          cnt_d[i]  = '0;
          per_d[i]  = per_sh_q[i];
          duty_d[i] = duty_sh_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        // PWM compares against the duty in force during this count, not the one being loaded.
        case (mode_q[i])
          MODE_TOGGLE: sig_d[i] = sig_q[i] ^ wrap_ev_s[i];
          MODE_PULSE:  sig_d[i] = wrap_ev_s[i];
          MODE_PWM:    sig_d[i] = (cnt_q[i] < duty_q[i]);
          default:     sig_d[i] = 1'b0;
        endcase
      end

      oe_d[i] = (mode_d[i] != MODE_OFF);
    end
  end

  // State registers; reset loads the configured defaults into every channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]    <= mode_e'(RESET_MODE);
        cnt_q[i]     <= '0;
        per_q[i]     <= RESET_PERIOD;
        duty_q[i]    <= RESET_DUTY;
        per_sh_q[i]  <= RESET_PERIOD;
        duty_sh_q[i] <= RESET_DUTY;
      end
      sig_q  <= '0;
      oe_q   <= {CHANNELS{RESET_MODE != 2'd0}};
      wrap_q <= '0;
    end else begin
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      duty_q    <= duty_d;
      per_sh_q  <= per_sh_d;
      duty_sh_q <= duty_sh_d;
      sig_q     <= sig_d;
      oe_q      <= oe_d;
      wrap_q    <= wrap_d;
    end
  end

  assign sig    = sig_q;
  assign sig_oe = oe_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_heartbeat_multi.sv
// Directed bench for heartbeat_multi: a cycle model pushes expected outputs to a
// scoreboard queue on every driven cycle, plus directed waveform-shape checks.
module tb_heartbeat_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [2:0] cfg_chan;
  logic [1:0] cfg_field;
  logic [3:0] cfg_data;
  logic       restart;
  logic [3:0] sig, sig_oe, wrap;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] s;
    logic [3:0] oe;
    logic [3:0] w;
  } exp_t;
  exp_t sbq[$];

  logic [1:0] m_mode [4];
  logic [3:0] m_cnt  [4];
  logic [3:0] m_per  [4];
  logic [3:0] m_duty [4];
  logic [3:0] m_psh  [4];
  logic [3:0] m_dsh  [4];
  logic       m_sig  [4];
  logic       m_wrap [4];

  heartbeat_multi #(
    .CHANNELS(4), .CNT_W(4), .CH_W(3),
    .RESET_MODE(2'd1), .RESET_PERIOD(4'd3), .RESET_DUTY(4'd0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_field(cfg_field), .cfg_data(cfg_data), .restart(restart),
    .sig(sig), .sig_oe(sig_oe), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_mode[i] = 2'd1; m_cnt[i] = 4'd0; m_per[i] = 4'd3; m_duty[i] = 4'd0;
      m_psh[i] = 4'd3;  m_dsh[i] = 4'd0; m_sig[i] = 1'b0; m_wrap[i] = 1'b0;
    end
  endtask

  // Advance the reference model by one clock using the inputs currently driven.
  task automatic model_adv();
    for (int i = 0; i < 4; i++) begin
      logic       wr, mw, ev;
      logic [3:0] old_psh, old_dsh;
      wr = cfg_we && (cfg_chan == 3'(i)) && (cfg_field != 2'd3);
      mw = wr && (cfg_field == 2'd2);
      ev = (m_mode[i] != 2'd0) && (m_cnt[i] == m_per[i]);
      old_psh = m_psh[i];
      old_dsh = m_dsh[i];
      if (restart || mw) begin
        if (mw) m_mode[i] = cfg_data[1:0];
        m_cnt[i] = 4'd0; m_sig[i] = 1'b0; m_wrap[i] = 1'b0;
        m_per[i] = old_psh; m_duty[i] = old_dsh;
      end else if (m_mode[i] == 2'd0) begin
        m_cnt[i] = 4'd0; m_sig[i] = 1'b0; m_wrap[i] = 1'b0;
      end else begin
        m_wrap[i] = ev;
        case (m_mode[i])
          2'd1:    if (ev) m_sig[i] = ~m_sig[i];
          2'd2:    m_sig[i] = ev;
          default: m_sig[i] = (m_cnt[i] < m_duty[i]);
        endcase
        if (ev) begin
          m_cnt[i] = 4'd0; m_per[i] = old_psh; m_duty[i] = old_dsh;
        end else begin
          m_cnt[i] = m_cnt[i] + 4'd1;
        end
      end
      if (wr && cfg_field == 2'd0) m_psh[i] = cfg_data;
      if (wr && cfg_field == 2'd1) m_dsh[i] = cfg_data;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.s[i]  = m_sig[i];
      e.oe[i] = (m_mode[i] != 2'd0);
      e.w[i]  = m_wrap[i];
    end
    return e;
  endfunction

  task automatic step();
    exp_t e;
    model_adv();
    sbq.push_back(model_out());
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("sig", 32'(sig), 32'(e.s));
    check("sig_oe", 32'(sig_oe), 32'(e.oe));
    check("wrap", 32'(wrap), 32'(e.w));
    cfg_we  = 1'b0;
    restart = 1'b0;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [1:0] f, input logic [3:0] d);
    cfg_we = 1'b1; cfg_chan = ch; cfg_field = f; cfg_data = d;
    step();
  endtask

  initial begin
    int cnt_a, cnt_b;
    logic prev;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_chan = 3'd0; cfg_field = 2'd0;
    cfg_data = 4'd0; restart = 1'b0;
    model_reset();
    #12;
    check("reset_sig", 32'(sig), 32'h0);
    check("reset_oe", 32'(sig_oe), 32'hF);
    check("reset_wrap", 32'(wrap), 32'h0);
    rst_n = 1'b1;

    // Reset defaults: TOGGLE with period 3 -> toggle and wrap every 4 cycles.
    cnt_a = 0; cnt_b = 0; prev = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (sig[0] != prev) cnt_a++;
      prev = sig[0];
      if (wrap[0]) cnt_b++;
    end
    check("toggle_edges_16cyc", 32'(cnt_a), 32'd4);
    check("wrap_pulses_16cyc", 32'(cnt_b), 32'd4);

    // Ch1 PWM, period 9 duty 3: 3 high out of 10.
    wr(3'd1, 2'd0, 4'd9);
    wr(3'd1, 2'd1, 4'd3);
    wr(3'd1, 2'd2, 4'd3);
    cnt_a = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (sig[1]) cnt_a++;
    end
    check("pwm_high_20cyc", 32'(cnt_a), 32'd6);
    wr(3'd1, 2'd1, 4'd0);
    cnt_a = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (k >= 10 && sig[1]) cnt_a++;
    end
    check("pwm_duty0_const0", 32'(cnt_a), 32'd0);
    wr(3'd1, 2'd1, 4'd12);
    cnt_a = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (k >= 10 && sig[1]) cnt_a++;
    end
    check("pwm_duty_gt_p_const1", 32'(cnt_a), 32'd15);

    // Ch2 PULSE with period 0 is high every cycle; period 4 then pulses every 5.
    wr(3'd2, 2'd0, 4'd0);
    wr(3'd2, 2'd2, 4'd2);
    cnt_a = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (sig[2]) cnt_a++;
    end
    check("pulse_p0_every_cycle", 32'(cnt_a), 32'd6);
    wr(3'd2, 2'd0, 4'd4);
    step();
    check("pulse_old_period_holds", 32'(sig[2]), 32'd1);
    cnt_a = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (sig[2]) cnt_a++;
    end
    check("pulse_p4_20cyc", 32'(cnt_a), 32'd4);

    // Ch0/ch3 TOGGLE at periods 5 and 7, then a restart aligns them.
    wr(3'd0, 2'd0, 4'd5);
    wr(3'd3, 2'd0, 4'd7);
    for (int k = 0; k < 50; k++) step();
    restart = 1'b1;
    step();
    check("restart_sig_zero", 32'(sig), 32'h0);
    check("restart_wrap_zero", 32'(wrap), 32'h0);
    for (int k = 1; k <= 24; k++) begin
      step();
      check("aligned_wrap_ch0", 32'(wrap[0]), 32'((k % 6) == 0));
      check("aligned_wrap_ch3", 32'(wrap[3]), 32'((k % 8) == 0));
    end

    // Restart with a same-cycle PERIOD write: old period 5 first, then 2.
    restart = 1'b1;
    wr(3'd0, 2'd0, 4'd2);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("restart_old_then_new_period", 32'(wrap[0]), 32'(k == 6 || k == 9 || k == 12));
    end
    wr(3'd4, 2'd2, 4'd0);
    wr(3'd0, 2'd3, 4'd0);
    check("invalid_writes_ignored", 32'(sig_oe), 32'hF);

    // Ch1 OFF: outputs drop at once and no wraps follow.
    wr(3'd1, 2'd2, 4'd0);
    check("off_oe", 32'(sig_oe[1]), 32'd0);
    check("off_sig", 32'(sig[1]), 32'd0);
    cnt_a = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (wrap[1]) cnt_a++;
    end
    check("off_no_wrap", 32'(cnt_a), 32'd0);

    // Mid-PWM asynchronous reset.
    wr(3'd1, 2'd1, 4'd3);
    wr(3'd1, 2'd2, 4'd3);
    step();
    step();
    check("pwm_high_before_reset", 32'(sig[1]), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_sig", 32'(sig), 32'h0);
    check("async_reset_oe", 32'(sig_oe), 32'hF);
    check("async_reset_wrap", 32'(wrap), 32'h0);
    model_reset();
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) step();
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
